// File: rtl/bru_pkg.sv
// bru_pkg: shared types and constants for the branch resolve unit.
//   pred_meta_t : BTB prediction metadata carried alongside an instruction
//   btb_upd_t   : BTB update write payload
//   PC_INC      : sequential PC increment
//   pc_inc()    : modulo-2^32 sequential next PC
package bru_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    // Per-instruction prediction metadata; pred_taken = btb_hit & btb_br at fetch.
    typedef struct packed {
        logic            valid;
        logic            hit;
        logic            pred_taken;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] pred_target;
    } pred_meta_t;

    // BTB update write payload.
    typedef struct packed {
        logic            write;
        logic            br;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } btb_upd_t;

    // Sequential successor; wraps 0xFFFF_FFFC -> 0x0000_0000.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/bru_meta_pipe.sv
// bru_meta_pipe: IF -> ID -> EX prediction metadata pipeline.
//   clk, rst    : clock, asynchronous active-high reset
//   if_meta     : metadata captured at fetch
//   id_stall    : hold the IF/ID register (EX receives a bubble)
//   ex_stall    : hold the ID/EX register (also holds IF/ID)
//   flush       : invalidate ID and EX on the next edge, overriding stalls
//   ex_meta     : metadata of the instruction currently in EX
module bru_meta_pipe
    import bru_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  pred_meta_t if_meta,
    input  logic       id_stall,
    input  logic       ex_stall,
    input  logic       flush,
    output pred_meta_t ex_meta
);

    pred_meta_t id_q;
    pred_meta_t id_d;
    pred_meta_t ex_q;
    pred_meta_t ex_d;

    // Stage advance: flush kills both stages; ex_stall freezes both;
    // id_stall alone freezes ID and sends a bubble into EX.
    always_comb begin
        id_d = id_q;
        ex_d = ex_q;
        if (flush) begin
            id_d.valid = 1'b0;
            ex_d.valid = 1'b0;
        end else begin
            if (!(id_stall || ex_stall)) begin
                id_d = if_meta;
            end
            if (!ex_stall) begin
                ex_d = id_q;
                if (id_stall) begin
                    ex_d.valid = 1'b0;
                end
            end
        end
    end

    // Metadata registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q <= '0;
            ex_q <= '0;
        end else begin
            id_q <= id_d;
            ex_q <= ex_d;
        end
    end

    assign ex_meta = ex_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: carries each fetch's BTB prediction to EX, compares it
// with the actual branch outcome, raises flush/redirect on mispredict and
// issues the BTB update write one cycle after resolution.
//   clk, rst                 : clock, asynchronous active-high reset
//   if_valid/if_pc           : fetch slot
//   if_btb_hit/if_btb_br     : BTB lookup result for if_pc
//   if_pred_target           : BTB predicted target
//   id_stall, ex_stall       : pipeline holds
//   ex_is_branch/ex_taken    : actual EX outcome (jumps drive ex_taken=1)
//   ex_target                : actual computed target
//   flush, redirect_pc       : combinational mispredict recovery
//   btb_write/btb_br/
//   btb_pc_wr/
//   btb_pc_predict_wr        : registered BTB update
//   cnt_branch/cnt_mispredict: saturating performance counters
// Build option: define BRU_PERF_CNT_EN to include the performance counters;
// otherwise both counter ports are tied to zero.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [PC_W-1:0]      if_pc,
    input  logic                 if_btb_hit,
    input  logic                 if_btb_br,
    input  logic [PC_W-1:0]      if_pred_target,
    input  logic                 id_stall,
    input  logic                 ex_stall,
    input  logic                 ex_is_branch,
    input  logic                 ex_taken,
    input  logic [PC_W-1:0]      ex_target,
    output logic                 flush,
    output logic [PC_W-1:0]      redirect_pc,
    output logic                 btb_write,
    output logic                 btb_br,
    output logic [PC_W-1:0]      btb_pc_wr,
    output logic [PC_W-1:0]      btb_pc_predict_wr,
    output logic [CNT_WIDTH-1:0] cnt_branch,
    output logic [CNT_WIDTH-1:0] cnt_mispredict
);

    pred_meta_t      if_meta_c;
    pred_meta_t      ex_meta;
    logic            resolve_c;
    logic            mispredict_c;
    logic [PC_W-1:0] redirect_c;
    logic [PC_W-1:0] ex_pc_seq_c;
    btb_upd_t        upd_d;
    btb_upd_t        upd_q;

    // Fetch-side metadata capture.
    always_comb begin
        if_meta_c             = '0;
        if_meta_c.valid       = if_valid;
        if_meta_c.hit         = if_btb_hit;
        if_meta_c.pred_taken  = if_btb_hit & if_btb_br;
        if_meta_c.pc          = if_pc;
        if_meta_c.pred_target = if_pred_target;
    end

    bru_meta_pipe u_meta_pipe (
        .clk      (clk),
        .rst      (rst),
        .if_meta  (if_meta_c),
        .id_stall (id_stall),
        .ex_stall (ex_stall),
        .flush    (mispredict_c),
        .ex_meta  (ex_meta)
    );

    assign resolve_c   = ex_meta.valid & ~ex_stall;
    assign ex_pc_seq_c = pc_inc(ex_meta.pc);

    // Resolve: mispredict detection, redirect target and BTB update request.
    // Update fields hold their last written value when no write is scheduled.
    always_comb begin
        mispredict_c = 1'b0;
        redirect_c   = '0;
        upd_d        = upd_q;
        upd_d.write  = 1'b0;
        if (resolve_c) begin
            if (ex_is_branch) begin
                if (ex_taken) begin
                    mispredict_c = ~(ex_meta.pred_taken &&
                                     (ex_meta.pred_target == ex_target));
                    redirect_c   = ex_target;
                    upd_d.write  = 1'b1;
                    upd_d.br     = 1'b1;
                    upd_d.pc     = ex_meta.pc;
                    upd_d.target = ex_target;
                end else begin
                    mispredict_c = ex_meta.pred_taken;
                    redirect_c   = ex_pc_seq_c;
                    // A not-taken branch that missed stays out of the table.
                    if (ex_meta.hit) begin
                        upd_d.write  = 1'b1;
                        upd_d.br     = 1'b0;
                        upd_d.pc     = ex_meta.pc;
                        upd_d.target = ex_target;
                    end
                end
            end else begin
                // Non-branch that aliased onto a taken BTB entry.
                mispredict_c = ex_meta.pred_taken;
                redirect_c   = ex_pc_seq_c;
                if (ex_meta.pred_taken) begin
                    upd_d.write  = 1'b1;
                    upd_d.br     = 1'b0;
                    upd_d.pc     = ex_meta.pc;
                    upd_d.target = ex_pc_seq_c;
                end
            end
        end
    end

    // BTB update register; reset drops any pending write immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_q <= '0;
        end else begin
            upd_q <= upd_d;
        end
    end

    assign flush             = mispredict_c;
    assign redirect_pc       = mispredict_c ? redirect_c : '0;
    assign btb_write         = upd_q.write;
    assign btb_br            = upd_q.br;
    assign btb_pc_wr         = upd_q.pc;
    assign btb_pc_predict_wr = upd_q.target;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_branch_q;
    logic [CNT_WIDTH-1:0] cnt_branch_d;
    logic [CNT_WIDTH-1:0] cnt_mispredict_q;
    logic [CNT_WIDTH-1:0] cnt_mispredict_d;

    // Saturating event counters.
    always_comb begin
        cnt_branch_d     = cnt_branch_q;
        cnt_mispredict_d = cnt_mispredict_q;
        if (resolve_c && ex_is_branch && (cnt_branch_q != '1)) begin
            cnt_branch_d = cnt_branch_q + CNT_WIDTH'(1);
        end
        if (mispredict_c && (cnt_mispredict_q != '1)) begin
            cnt_mispredict_d = cnt_mispredict_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_branch_q     <= '0;
            cnt_mispredict_q <= '0;
        end else begin
            cnt_branch_q     <= cnt_branch_d;
            cnt_mispredict_q <= cnt_mispredict_d;
        end
    end

    assign cnt_branch     = cnt_branch_q;
    assign cnt_mispredict = cnt_mispredict_q;
`else
    assign cnt_branch     = '0;
    assign cnt_mispredict = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios followed by a randomized
// run checked against a behavioural model of the prediction pipeline.
module tb_branch_resolve_unit;

    localparam int unsigned CW = 32;
`ifdef BRU_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_valid, if_btb_hit, if_btb_br;
    logic [31:0]   if_pc, if_pred_target;
    logic          id_stall, ex_stall, ex_is_branch, ex_taken;
    logic [31:0]   ex_target;
    logic          flush, btb_write, btb_br;
    logic [31:0]   redirect_pc, btb_pc_wr, btb_pc_predict_wr;
    logic [CW-1:0] cnt_branch, cnt_mispredict;

    int vectors = 0;
    int errors  = 0;

    branch_resolve_unit #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc), .if_btb_hit(if_btb_hit),
        .if_btb_br(if_btb_br), .if_pred_target(if_pred_target),
        .id_stall(id_stall), .ex_stall(ex_stall),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .btb_write(btb_write), .btb_br(btb_br), .btb_pc_wr(btb_pc_wr),
        .btb_pc_predict_wr(btb_pc_predict_wr),
        .cnt_branch(cnt_branch), .cnt_mispredict(cnt_mispredict)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_if(input bit v, input logic [31:0] pc, input bit hit,
                          input bit br, input logic [31:0] tgt);
        if_valid = v; if_pc = pc; if_btb_hit = hit; if_btb_br = br; if_pred_target = tgt;
    endtask

    task automatic drv_ex(input bit isb, input bit tk, input logic [31:0] tgt);
        ex_is_branch = isb; ex_taken = tk; ex_target = tgt;
    endtask

    task automatic idle();
        drv_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drv_ex(1'b0, 1'b0, 32'h0);
        id_stall = 1'b0;
        ex_stall = 1'b0;
    endtask

    // Put one instruction into EX: two clean cycles behind IF.
    task automatic load_ex(input logic [31:0] pc, input bit hit, input bit br,
                           input logic [31:0] tgt);
        drv_if(1'b1, pc, hit, br, tgt);
        tick();
        drv_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({flush, redirect_pc, btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: flush=%b redir=%h wr=%b br=%b pc=%h tgt=%h, required all 0",
                     flush, redirect_pc, btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        vectors++;
        if ({cnt_branch, cnt_mispredict} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d, required 0/0", cnt_branch, cnt_mispredict);
        end
        rst = 1'b0;
        tick();
    endtask

    // Hit, predicted taken to 0x200, actually taken to 0x200.
    task automatic test_correct_taken();
        load_ex(32'h100, 1'b1, 1'b1, 32'h200);
        drv_ex(1'b1, 1'b1, 32'h200);
        #1;
        vectors++;
        if (flush !== 1'b0) begin
            errors++; $display("FAIL c1_flush: got %b, required 0", flush);
        end
        tick();
        drv_ex(1'b0, 1'b0, 32'h0);
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b1, 32'h100, 32'h200}) begin
            errors++;
            $display("FAIL c1_update: got wr=%b br=%b pc=%h tgt=%h, required 1 1 00000100 00000200",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        tick();
        vectors++;
        if (btb_write !== 1'b0) begin
            errors++; $display("FAIL c1_pulse: btb_write got %b, required 0", btb_write);
        end
    endtask

    // Miss, actually taken to 0x300; younger aliasing instructions are killed.
    task automatic test_taken_miss();
        drv_if(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        tick();
        drv_if(1'b1, 32'h1F0, 1'b1, 1'b1, 32'h500);
        tick();
        drv_if(1'b1, 32'h1F4, 1'b1, 1'b1, 32'h600);
        drv_ex(1'b1, 1'b1, 32'h300);
        #1;
        vectors++;
        if ({flush, redirect_pc} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL c2_flush: got %b/%h, required 1/00000300", flush, redirect_pc);
        end
        tick();
        drv_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        drv_ex(1'b0, 1'b0, 32'h0);
        #1;
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b1, 32'h104, 32'h300}) begin
            errors++;
            $display("FAIL c2_update: got wr=%b br=%b pc=%h tgt=%h, required 1 1 00000104 00000300",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        vectors++;
        if (flush !== 1'b0) begin
            errors++; $display("FAIL c2_ex_cleared: flush got %b, required 0", flush);
        end
        tick();
        vectors++;
        if ({flush, btb_write} !== 2'b00) begin
            errors++; $display("FAIL c2_id_cleared: flush/wr got %b/%b, required 0/0", flush, btb_write);
        end
    endtask

    // Predicted taken to 0x400, actually not taken.
    task automatic test_not_taken_hit();
        load_ex(32'h108, 1'b1, 1'b1, 32'h400);
        drv_ex(1'b1, 1'b0, 32'h400);
        #1;
        vectors++;
        if ({flush, redirect_pc} !== {1'b1, 32'h10C}) begin
            errors++; $display("FAIL c3_flush: got %b/%h, required 1/0000010c", flush, redirect_pc);
        end
        tick();
        drv_ex(1'b0, 1'b0, 32'h0);
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b0, 32'h108, 32'h400}) begin
            errors++;
            $display("FAIL c3_update: got wr=%b br=%b pc=%h tgt=%h, required 1 0 00000108 00000400",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        tick();
    endtask

    // Non-branch hitting a taken entry.
    task automatic test_alias();
        load_ex(32'h110, 1'b1, 1'b1, 32'h700);
        drv_ex(1'b0, 1'b0, 32'h0);
        #1;
        vectors++;
        if ({flush, redirect_pc} !== {1'b1, 32'h114}) begin
            errors++; $display("FAIL c4_flush: got %b/%h, required 1/00000114", flush, redirect_pc);
        end
        tick();
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b0, 32'h110, 32'h114}) begin
            errors++;
            $display("FAIL c4_update: got wr=%b br=%b pc=%h tgt=%h, required 1 0 00000110 00000114",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        tick();
    endtask

    // Mispredicting branch held by ex_stall for three cycles.
    task automatic test_ex_stall();
        load_ex(32'h120, 1'b0, 1'b0, 32'h0);
        ex_stall = 1'b1;
        drv_ex(1'b1, 1'b1, 32'h800);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (flush !== 1'b0) begin
                errors++; $display("FAIL stall_flush_%0d: got %b, required 0", k, flush);
            end
            tick();
            vectors++;
            if (btb_write !== 1'b0) begin
                errors++; $display("FAIL stall_write_%0d: got %b, required 0", k, btb_write);
            end
        end
        ex_stall = 1'b0;
        #1;
        vectors++;
        if ({flush, redirect_pc} !== {1'b1, 32'h800}) begin
            errors++; $display("FAIL stall_release: got %b/%h, required 1/00000800", flush, redirect_pc);
        end
        tick();
        drv_ex(1'b0, 1'b0, 32'h0);
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b1, 32'h120, 32'h800}) begin
            errors++;
            $display("FAIL stall_update: got wr=%b br=%b pc=%h tgt=%h, required 1 1 00000120 00000800",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        tick();
        vectors++;
        if (btb_write !== 1'b0) begin
            errors++; $display("FAIL stall_single: btb_write got %b, required 0", btb_write);
        end
    endtask

    // Four branches and four mispredicts resolved so far.
    task automatic test_counters();
        vectors++;
        if ({cnt_branch, cnt_mispredict} !== {(PERF ? CW'(4) : CW'(0)), (PERF ? CW'(4) : CW'(0))}) begin
            errors++;
            $display("FAIL counters: got %0d/%0d, required %0d/%0d", cnt_branch, cnt_mispredict,
                     PERF ? 4 : 0, PERF ? 4 : 0);
        end
    endtask

    // Not-taken branch that missed: neither flush nor write.
    task automatic test_nt_miss();
        load_ex(32'h130, 1'b0, 1'b0, 32'h0);
        drv_ex(1'b1, 1'b0, 32'h900);
        #1;
        vectors++;
        if (flush !== 1'b0) begin
            errors++; $display("FAIL ntmiss_flush: got %b, required 0", flush);
        end
        tick();
        drv_ex(1'b0, 1'b0, 32'h0);
        vectors++;
        if (btb_write !== 1'b0) begin
            errors++; $display("FAIL ntmiss_write: got %b, required 0", btb_write);
        end
    endtask

    // id_stall alone: EX sees bubbles while ID holds its instruction.
    task automatic test_id_stall();
        drv_if(1'b1, 32'h140, 1'b1, 1'b1, 32'hA00);
        tick();
        drv_if(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        id_stall = 1'b1;
        tick();
        #1;
        vectors++;
        if (flush !== 1'b0) begin
            errors++; $display("FAIL idstall_bubble: flush got %b, required 0", flush);
        end
        tick();
        vectors++;
        if ({flush, btb_write} !== 2'b00) begin
            errors++; $display("FAIL idstall_noresolve: flush/wr got %b/%b, required 0/0", flush, btb_write);
        end
        id_stall = 1'b0;
        tick();
        #1;
        vectors++;
        if ({flush, redirect_pc} !== {1'b1, 32'h144}) begin
            errors++; $display("FAIL idstall_held: got %b/%h, required 1/00000144", flush, redirect_pc);
        end
        tick();
        vectors++;
        if ({btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr} !== {1'b1, 1'b0, 32'h140, 32'h144}) begin
            errors++;
            $display("FAIL idstall_update: got wr=%b br=%b pc=%h tgt=%h, required 1 0 00000140 00000144",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr);
        end
        tick();
    endtask

    // Reset while an update is on the outputs.
    task automatic test_reset_pending();
        load_ex(32'h150, 1'b0, 1'b0, 32'h0);
        drv_ex(1'b1, 1'b1, 32'hB00);
        tick();
        drv_ex(1'b0, 1'b0, 32'h0);
        vectors++;
        if (btb_write !== 1'b1) begin
            errors++; $display("FAIL rstpend_armed: btb_write got %b, required 1", btb_write);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({flush, redirect_pc, btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr,
             cnt_branch, cnt_mispredict} !== '0) begin
            errors++;
            $display("FAIL rstpend_drop: wr=%b br=%b pc=%h tgt=%h cnt=%0d/%0d, required all 0",
                     btb_write, btb_br, btb_pc_wr, btb_pc_predict_wr, cnt_branch, cnt_mispredict);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          v;
        bit          hit;
        bit          pt;
        logic [31:0] pc;
        logic [31:0] tgt;
    } minst_t;

    // Randomized traffic against a model of the in-flight instructions.
    task automatic test_random();
        minst_t      m_id, m_ex, fetched;
        bit          e_flush, e_w, e_br;
        logic [31:0] e_redir, e_pc, e_tgt, r;
        int unsigned m_cb, m_cm;

        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        m_id = '{v: 1'b0, hit: 1'b0, pt: 1'b0, pc: 32'h0, tgt: 32'h0};
        m_ex = m_id;
        m_cb = 0;
        m_cm = 0;

        for (int n = 0; n < 2000; n++) begin
            r = $urandom();
            r[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFFC;
            fetched.v   = ($urandom_range(0, 3) != 0);
            fetched.pc  = r;
            fetched.hit = $urandom_range(0, 1) != 0;
            fetched.pt  = fetched.hit && ($urandom_range(0, 2) != 0);
            fetched.tgt = $urandom() & 32'hFFFF_FFFC;
            drv_if(fetched.v, fetched.pc, fetched.hit,
                   fetched.hit ? fetched.pt : bit'($urandom_range(0, 1)), fetched.tgt);
            id_stall = ($urandom_range(0, 4) == 0);
            ex_stall = ($urandom_range(0, 5) == 0);
            r = $urandom() & 32'hFFFF_FFFC;
            drv_ex($urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0,
                   ($urandom_range(0, 1) != 0) ? m_ex.tgt : r);
            #1;

            // Outcome from the resolution table.
            e_flush = 1'b0; e_w = 1'b0; e_br = 1'b0;
            e_redir = 32'h0; e_pc = m_ex.pc; e_tgt = 32'h0;
            if (m_ex.v && !ex_stall) begin
                if (ex_is_branch) begin
                    if (m_cb != 32'hFFFF_FFFF) m_cb++;
                    if (ex_taken) begin
                        e_flush = !(m_ex.pt && (m_ex.tgt == ex_target));
                        e_redir = ex_target;
                        e_w = 1'b1; e_br = 1'b1; e_tgt = ex_target;
                    end else begin
                        e_flush = m_ex.pt;
                        e_redir = m_ex.pc + 32'd4;
                        if (m_ex.hit) begin
                            e_w = 1'b1; e_tgt = ex_target;
                        end
                    end
                end else begin
                    e_flush = m_ex.pt;
                    e_redir = m_ex.pc + 32'd4;
                    if (m_ex.pt) begin
                        e_w = 1'b1; e_tgt = m_ex.pc + 32'd4;
                    end
                end
                if (e_flush && m_cm != 32'hFFFF_FFFF) m_cm++;
            end
            if (!e_flush) e_redir = 32'h0;

            vectors++;
            if ({flush, redirect_pc} !== {e_flush, e_redir}) begin
                errors++;
                $display("FAIL rnd_resolve[%0d]: got %b/%h, required %b/%h",
                         n, flush, redirect_pc, e_flush, e_redir);
            end

            // Advance the model: flush kills everything in flight.
            if (e_flush) begin
                m_ex.v = 1'b0;
                m_id.v = 1'b0;
            end else if (!ex_stall) begin
                m_ex = m_id;
                if (id_stall) m_ex.v = 1'b0;
                else m_id = fetched;
            end

            tick();
            vectors++;
            if (btb_write !== e_w) begin
                errors++; $display("FAIL rnd_write[%0d]: got %b, required %b", n, btb_write, e_w);
            end else if (e_w) begin
                vectors++;
                if ({btb_br, btb_pc_wr, btb_pc_predict_wr} !== {e_br, e_pc, e_tgt}) begin
                    errors++;
                    $display("FAIL rnd_update[%0d]: got br=%b pc=%h tgt=%h, required %b %h %h",
                             n, btb_br, btb_pc_wr, btb_pc_predict_wr, e_br, e_pc, e_tgt);
                end
            end
            vectors++;
            if ({cnt_branch, cnt_mispredict} !== {(PERF ? CW'(m_cb) : CW'(0)), (PERF ? CW'(m_cm) : CW'(0))}) begin
                errors++;
                $display("FAIL rnd_counters[%0d]: got %0d/%0d, required %0d/%0d", n,
                         cnt_branch, cnt_mispredict, PERF ? m_cb : 0, PERF ? m_cm : 0);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_correct_taken();
        test_taken_miss();
        test_not_taken_hit();
        test_alias();
        test_ex_stall();
        test_counters();
        test_nt_miss();
        test_id_stall();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage counterpart of the branch target buffer. It carries each fetch's BTB prediction alongside the instruction, from IF through ID to EX. In EX it compares that prediction with the actual branch outcome and raises a flush/redirect on mispredict. One cycle later it issues the BTB update write (write, br, pc_wr, pc_predict_wr), closing the predictor loop.

## Interface
- CNT_WIDTH, 32, width of performance counters
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_valid  in  1  IF stage holds a real instruction
- if_pc  in  32  fetch PC
- if_btb_hit  in  1  BTB hit for if_pc
- if_btb_br  in  1  BTB predicts taken for if_pc
- if_pred_target  in  32  BTB predicted target
- id_stall  in  1  hold IF/ID metadata register
- ex_stall  in  1  hold ID/EX metadata register; EX instruction does not resolve
- ex_is_branch  in  1  EX instruction is a branch or jump
- ex_taken  in  1  actual outcome (jumps drive 1)
- ex_target  in  32  actual computed target
- flush  out  1  kill ID and EX contents (combinational)
- redirect_pc  out  32  correct next PC, valid when flush=1
- btb_write  out  1  BTB write strobe (registered)
- btb_br  out  1  new BTB state, 1 = taken
- btb_pc_wr  out  32  PC of the entry to write
- btb_pc_predict_wr  out  32  target to store
- cnt_branch  out  CNT_WIDTH  resolved branches
- cnt_mispredict  out  CNT_WIDTH  mispredicts, including aliased non-branch hits

## Operation
- Each metadata stage holds {valid, pc, pred_taken = btb_hit & btb_br, hit, pred_target}.
- Stage advance on each clock edge:
  - ID ← IF when !id_stall.
  - EX ← ID when !ex_stall.
  - When id_stall=1 and ex_stall=0, EX gets a bubble (valid=0).
  - ex_stall=1 forces id_stall behaviour as well.
- Resolution occurs when ex.valid=1 and ex_stall=0. Cases:
  - Branch, actual taken, pred_taken=1, pred_target==ex_target: correct, no flush.
  - Branch, actual taken, not predicted taken or target mismatch: mispredict; redirect_pc=ex_target.
  - Branch, actual not taken, pred_taken=1: mispredict; redirect_pc=ex.pc+4.
  - Branch, actual not taken, pred_taken=0: correct.
  - Non-branch with pred_taken=1 (alias): mispredict; redirect_pc=ex.pc+4.
- flush=1 exactly on mispredict. On the next edge, ID and EX valid are cleared. Flush overrides id_stall for the ID register.
- A BTB update is scheduled on resolution when any of these holds:
  - branch actually taken: br=1, target=ex_target;
  - branch not taken and hit=1: br=0, target=ex_target;
  - non-branch alias hit: br=0, target=ex.pc+4.
- Not-taken branches that missed the BTB are not written, to avoid table pollution.
- PC arithmetic: 32-bit modulo; pc+4 wraps at 0xFFFF_FFFC → 0x0000_0000.

## Timing
- Reset values:
  - all metadata valid=0;
  - flush=0, redirect_pc=0;
  - btb_write=0, btb_br=0, btb_pc_wr=0, btb_pc_predict_wr=0;
  - counters=0.
- Latency:
  - IF→EX metadata: 2 cycles absent stalls.
  - flush/redirect: same cycle as resolution.
  - btb_write: exactly 1 cycle after resolution, single-cycle pulse per resolved instruction.
- Back-to-back resolutions give consecutive btb_write pulses.
- No duplicate update while ex_stall holds an instruction.
- A BTB update and an IF read of the same entry in the same cycle are legal: IF sees the old contents.
- Reset mid-operation: any pending btb_write is dropped immediately and the outputs return to their reset values.

## Configuration
- BRU_PERF_CNT_EN defined: cnt_branch counts each resolved ex_is_branch; cnt_mispredict counts each flush. Both saturate at all-ones.
- BRU_PERF_CNT_EN undefined: counter logic is absent, and both ports stay present, tied to 0.

## Structure
- Package bru_pkg holds:
  - typedef pred_meta_t (valid, hit, pred_taken, pc, pred_target);
  - localparam PC_INC = 4;
  - typedef btb_upd_t (write, br, pc, target).
- Sub-module bru_meta_pipe: the two-stage IF→ID→EX pred_meta_t register pipeline with stall, bubble and flush handling. The top level holds the resolve, update and counter logic.

## Test plan
- Branch at 0x100, BTB hit, taken, target 0x200, actual taken to 0x200 → flush=0; btb_write=1 next cycle with br=1, pc_wr=0x100, predict_wr=0x200.
- Branch at 0x104, miss, actual taken to 0x300 → flush=1, redirect_pc=0x300; next cycle btb_write with br=1, target 0x300; ID/EX valid cleared.
- Branch at 0x108, hit predicted taken to 0x400, actual not taken → flush=1, redirect_pc=0x10C; update with br=0.
- Non-branch at 0x110 with an aliased taken hit → flush=1, redirect_pc=0x114, update br=0. Not-taken branch that missed the BTB → no flush, no btb_write.
- Stalls: ex_stall held 3 cycles on a mispredicting branch → flush only in the cycle ex_stall drops, one btb_write. id_stall=1 with ex_stall=0 → EX bubble, no resolution.
- Reset asserted while btb_write is pending → btb_write=0 immediately. Counters, with BRU_PERF_CNT_EN defined: after the cases above, cnt_branch=4, cnt_mispredict=4.
